// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Any depth >= 2; FWFT selects registered or fall-through read data.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wn,
    input  logic                  rn,
    input  logic [DATA_WIDTH-1:0] DATAIN,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] DATAOUT,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic rd_acc;
    logic wr_acc;

    // Flags come from the registered count only, never from wn/rn.
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign rd_acc = rn & ~empty;
    assign wr_acc = wn & (~full | rd_acc);

    // Next-state: pointers wrap by compare so any depth works.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (wr_acc) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (rd_acc) begin
            rptr_d  = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            dout_d  = mem_q[rptr_q];
            valid_d = 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = (ovf_q & ~clr_err) | (wn & ~wr_acc);
        unf_d = (unf_q & ~clr_err) | (rn & empty);
    end

    // Control state with synchronous reset taking priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge clock) begin
        if (!reset && wr_acc) begin
            mem_q[wptr_q] <= DATAIN;
        end
    end

    // Fall-through mode presents the head entry straight from the array.
    assign DATAOUT   = FWFT ? mem_q[rptr_q] : dout_q;
    assign valid     = FWFT ? ~empty : valid_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: a registered-read instance (DEPTH=10)
// and a fall-through instance (DEPTH=5), each checked against a queue model.
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults (DEPTH=10, FWFT=0)
    logic       rst0 = 1'b0, wn0 = 1'b0, rn0 = 1'b0, clr0 = 1'b0;
    logic [7:0] din0 = '0;
    logic [7:0] dout0;
    logic       val0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [3:0] cnt0;

    // Instance 1: DEPTH=5, FWFT=1
    logic       rst1 = 1'b1, wn1 = 1'b0, rn1 = 1'b0, clr1 = 1'b0;
    logic [7:0] din1 = '0;
    logic [7:0] dout1;
    logic       val1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0] cnt1;

    sync_fifo_flags u0 (
        .clock(clk), .reset(rst0), .wn(wn0), .rn(rn0), .DATAIN(din0),
        .clr_err(clr0), .DATAOUT(dout0), .valid(val0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flags #(.DEPTH(5), .FWFT(1'b1)) u1 (
        .clock(clk), .reset(rst1), .wn(wn1), .rn(rn1), .DATAIN(din1),
        .clr_err(clr1), .DATAOUT(dout1), .valid(val1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1)
    );

    int total  = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Model 0 (scoreboard queue plus registered output state)
    logic [7:0] m0q[$];
    logic [7:0] m0d = '0;
    bit         m0v, m0o, m0u;

    task automatic step0(input bit rs, input bit w, input bit r,
                         input bit c, input logic [7:0] d);
        bit emp, rd, wr;
        emp = (m0q.size() == 0);
        rd  = r && !emp;
        wr  = w && (m0q.size() < 10 || rd);
        rst0 = rs; wn0 = w; rn0 = r; clr0 = c; din0 = d;
        if (rs) begin
            m0q.delete();
            m0d = '0; m0v = 0; m0o = 0; m0u = 0;
        end else begin
            if (rd) begin
                m0d = m0q.pop_front();
                m0v = 1;
            end else begin
                m0v = 0;
            end
            if (wr) m0q.push_back(d);
            m0o = (m0o && !c) || (w && !wr);
            m0u = (m0u && !c) || (r && emp);
        end
        @(posedge clk);
        #1;
        rst0 = 0; wn0 = 0; rn0 = 0; clr0 = 0;
        chk("cnt0",   32'(cnt0),   32'(m0q.size()));
        chk("valid0", 32'(val0),   32'(m0v));
        chk("dout0",  32'(dout0),  32'(m0d));
        chk("full0",  32'(full0),  32'(m0q.size() == 10));
        chk("empty0", 32'(empty0), 32'(m0q.size() == 0));
        chk("af0",    32'(af0),    32'(m0q.size() >= 8));
        chk("ae0",    32'(ae0),    32'(m0q.size() <= 2));
        chk("ovf0",   32'(ovf0),   32'(m0o));
        chk("unf0",   32'(unf0),   32'(m0u));
    endtask

    // Model 1 (fall-through: head of queue is the output)
    logic [7:0] m1q[$];
    bit         m1o, m1u;

    task automatic step1(input bit rs, input bit w, input bit r,
                         input bit c, input logic [7:0] d);
        bit emp, rd, wr;
        emp = (m1q.size() == 0);
        rd  = r && !emp;
        wr  = w && (m1q.size() < 5 || rd);
        rst1 = rs; wn1 = w; rn1 = r; clr1 = c; din1 = d;
        if (rs) begin
            m1q.delete();
            m1o = 0; m1u = 0;
        end else begin
            if (rd) void'(m1q.pop_front());
            if (wr) m1q.push_back(d);
            m1o = (m1o && !c) || (w && !wr);
            m1u = (m1u && !c) || (r && emp);
        end
        @(posedge clk);
        #1;
        rst1 = 0; wn1 = 0; rn1 = 0; clr1 = 0;
        chk("cnt1",   32'(cnt1),   32'(m1q.size()));
        chk("valid1", 32'(val1),   32'(m1q.size() != 0));
        if (m1q.size() != 0) chk("dout1", 32'(dout1), 32'(m1q[0]));
        chk("full1",  32'(full1),  32'(m1q.size() == 5));
        chk("empty1", 32'(empty1), 32'(m1q.size() == 0));
        chk("af1",    32'(af1),    32'(m1q.size() >= 3));
        chk("ae1",    32'(ae1),    32'(m1q.size() <= 2));
        chk("ovf1",   32'(ovf1),   32'(m1o));
        chk("unf1",   32'(unf1),   32'(m1u));
    endtask

    initial begin
        // Reset defaults
        step0(1, 0, 0, 0, 8'd0);
        // Fill with 1..10, then overflow with 11
        for (int i = 1; i <= 10; i++) step0(0, 1, 0, 0, 8'(i));
        step0(0, 1, 0, 0, 8'd11);
        // Drain 1..10, then underflow; DATAOUT holds 10
        for (int i = 0; i < 10; i++) step0(0, 0, 1, 0, 8'd0);
        step0(0, 0, 1, 0, 8'd0);
        step0(0, 0, 0, 0, 8'd0);
        // Clear sticky errors
        step0(0, 0, 0, 1, 8'd0);
        // Write 7, read 5, then 20 concurrent cycles across the wrap
        for (int i = 0; i < 7; i++) step0(0, 1, 0, 0, 8'(20 + i));
        for (int i = 0; i < 5; i++) step0(0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 20; i++) step0(0, 1, 1, 0, 8'(100 + i));
        // Fill to full, then concurrent write/read at full
        for (int i = 0; i < 8; i++) step0(0, 1, 0, 0, 8'(150 + i));
        step0(0, 1, 1, 0, 8'd200);
        step0(0, 1, 1, 0, 8'd201);
        // Drain to 6, then reset with rn active
        for (int i = 0; i < 4; i++) step0(0, 0, 1, 0, 8'd0);
        step0(1, 0, 1, 0, 8'd0);
        step0(0, 1, 0, 0, 8'd55);
        step0(0, 0, 1, 0, 8'd0);
        step0(0, 0, 0, 0, 8'd0);

        // Fall-through instance
        step1(1, 0, 0, 0, 8'd0);
        step1(0, 1, 0, 0, 8'd9);
        step1(0, 0, 0, 0, 8'd0);
        step1(0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 12; i++)
            step1(0, (i % 3) != 2, (i % 4) == 3 || i >= 8, 0, 8'(40 + i));
        for (int i = 0; i < 4; i++) step1(0, 1, 0, 0, 8'(60 + i));
        step1(0, 1, 1, 0, 8'd70);
        for (int i = 0; i < 6; i++) step1(0, 0, 1, 0, 8'd0);
        step1(0, 0, 0, 1, 8'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
